alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
Initiator side of the 16-bit ALU interface. It accepts operation requests through a valid/ready handshake and drives the ALU operand and control ports from registered values. After a programmable settle time it captures result, zero indicator, skip decision and compare flags, then returns them through a valid/ready response channel. It sits between the control unit and the ALU and holds a persistent compare-flags register for later branch/skip use.

Parameters:
WIDTH, 16, data width of operands and result
SETTLE_CYCLES, 1, cycles ALU inputs are held before capture; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept request
req_op  in  4  ALU operation code 0..13; 14/15 illegal
req_a  in  WIDTH  operand A, signed
req_b  in  WIDTH  operand B, signed
alu_operand_A  out  WIDTH  registered operand A to ALU
alu_operand_B  out  WIDTH  registered operand B to ALU
alu_control  out  4  registered op code to ALU
alu_result  in  WIDTH  ALU result
alu_compare_flags  in  3  ALU {gt,lt,eq}
alu_zero_indicator  in  1  ALU zero flag
alu_should_skip  in  1  ALU skip decision
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes response
rsp_result  out  WIDTH  captured result
rsp_zero  out  1  captured zero flag
rsp_skip  out  1  captured skip decision
rsp_illegal  out  1  request op was 14 or 15
flags_reg  out  3  last captured compare flags
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (synchronous, active-high, clk edge): state IDLE. All outputs are 0 except req_ready=1: alu_* outputs, rsp_*, flags_reg=3'b000, busy=0. Reset wins over every other event in the same cycle, including reset during DRIVE or RESP. An in-flight operation is dropped with no response.
- FSM states: IDLE, DRIVE, RESP.
- IDLE: req_ready=1, busy=0. On req_valid&req_ready at edge E0:
  - Legal op (0..13): latch req_a, req_b, req_op into alu_operand_A/B and alu_control. Load settle counter with SETTLE_CYCLES. Go to DRIVE.
  - Illegal op (14/15): go directly to RESP with rsp_illegal=1, rsp_result=0, rsp_zero=0, rsp_skip=0. alu_* outputs and flags_reg are unchanged. rsp_valid is visible after E0.
- DRIVE: req_ready=0. alu_* outputs are stable. At each edge, if counter==1, capture and go to RESP; otherwise decrement. Capture occurs at edge E0+SETTLE_CYCLES; rsp_valid is high from that edge onward. For SETTLE_CYCLES=1, rsp_valid is asserted in the second cycle after acceptance.
- Capture rules:
  - rsp_result = alu_result for all legal ops. rsp_illegal=0.
  - rsp_zero = alu_zero_indicator for ops 0,1,2,5..10. Forced 0 for ops 3,4,11,12,13.
  - rsp_skip = alu_should_skip for ops 3,4,12,13. Forced 0 otherwise.
  - flags_reg <= alu_compare_flags only when op==11. Otherwise it is held.
- RESP: req_ready=0, rsp_valid=1. All rsp_* outputs are held stable until rsp_valid&rsp_ready. On that edge, rsp_valid goes 0 and the state returns to IDLE. No new request is accepted in the same cycle as the response handshake; there is one IDLE cycle minimum between operations.
- req_* inputs are ignored outside IDLE. A request held through backpressure is accepted on the first IDLE cycle.
- flags_reg persists across operations and is cleared only by reset.

Test Plan:
- Reset, SETTLE_CYCLES=1, op 0, A=5, B=-3 -> alu_control=0 after accept edge; rsp_valid 1 cycle later; rsp_result=2, rsp_zero=0, rsp_skip=0.
- Op 1, A=7, B=7 -> rsp_result=0, rsp_zero=1. Then op 11, A=-1, B=0 -> flags_reg=3'b010. A following op 0 leaves flags_reg=3'b010.
- Op 4, A=3, B=4 -> rsp_skip=0. Op 4, A=3, B=1 -> rsp_skip=1 with rsp_zero=0. Op 12, A=0 -> rsp_skip=1.
- rsp_ready held low 5 cycles with a second req_valid pending -> req_ready=0 and rsp_result stable throughout. After the handshake, one IDLE cycle, then the second request is accepted.
- Op 14 -> rsp_valid the cycle after accept, rsp_illegal=1, rsp_result=0, alu_control and flags_reg unchanged.
- SETTLE_CYCLES=4: capture exactly 4 edges after accept. Reset asserted during DRIVE -> next cycle rsp_valid=0, req_ready=1, busy=0, flags_reg=3'b000.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Initiator side of the 16-bit ALU interface: accepts an operation, drives the ALU from
// registered operands, captures the outcome after a settle time and returns it on a response channel.
module alu_op_sequencer #(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_operand_A,
    output logic [WIDTH-1:0] alu_operand_B,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [2:0]       alu_compare_flags,
    input  logic             alu_zero_indicator,
    input  logic             alu_should_skip,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_skip,
    output logic             rsp_illegal,
    output logic [2:0]       flags_reg,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [3:0] OP_CMP      = 4'd11;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, skip_q, skip_d, illegal_q, illegal_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [2:0]       flags_q, flags_d;
    logic             req_ready_q, req_ready_d, busy_q, busy_d;

    // Ops whose zero indicator is meaningful to the consumer
    function automatic logic zero_op(input logic [3:0] op);
        logic r;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: r = 1'b1;
            default:                                               r = 1'b0;
        endcase
        return r;
    endfunction

    // Ops that produce a skip decision
    function automatic logic skip_op(input logic [3:0] op);
        logic r;
        case (op)
            4'd3, 4'd4, 4'd12, 4'd13: r = 1'b1;
            default:                  r = 1'b0;
        endcase
        return r;
    endfunction

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        ctrl_d      = ctrl_q;
        result_d    = result_q;
        zero_d      = zero_q;
        skip_d      = skip_q;
        illegal_d   = illegal_q;
        rsp_valid_d = rsp_valid_q;
        flags_d     = flags_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_op >= 4'd14) begin
                        // Illegal ops bypass the ALU and answer immediately
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        illegal_d   = 1'b1;
                        result_d    = '0;
                        zero_d      = 1'b0;
                        skip_d      = 1'b0;
                    end else begin
                        state_d = DRIVE;
                        op_a_d  = req_a;
                        op_b_d  = req_b;
                        ctrl_d  = req_op;
                        cnt_d   = SETTLE_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DRIVE: begin
                if (cnt_q == 4'd1) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    illegal_d   = 1'b0;
                    result_d    = alu_result;
                    zero_d      = zero_op(ctrl_q) ? alu_zero_indicator : 1'b0;
                    skip_d      = skip_op(ctrl_q) ? alu_should_skip : 1'b0;
                    if (ctrl_q == OP_CMP) begin
                        flags_d = alu_compare_flags;
                    end else begin
                        flags_d = flags_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            ctrl_q      <= 4'd0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            skip_q      <= 1'b0;
            illegal_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            flags_q     <= 3'b000;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            ctrl_q      <= ctrl_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            skip_q      <= skip_d;
            illegal_q   <= illegal_d;
            rsp_valid_q <= rsp_valid_d;
            flags_q     <= flags_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign busy          = busy_q;
    assign alu_operand_A = op_a_q;
    assign alu_operand_B = op_b_q;
    assign alu_control   = ctrl_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_result    = result_q;
    assign rsp_zero      = zero_q;
    assign rsp_skip      = skip_q;
    assign rsp_illegal   = illegal_q;
    assign flags_reg     = flags_q;

endmodule
